// File: rtl/gaussian_blur_if.sv
// FIFO-side handshake bundle for the gaussian_blur stage: FWFT read port
// upstream, write port downstream.
interface gaussian_blur_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] in_dout;
    logic                  in_empty;
    logic                  in_rd_en;
    logic [DATA_WIDTH-1:0] out_din;
    logic                  out_full;
    logic                  out_wr_en;

    // master drives the FIFO side (bench / surrounding pipeline)
    modport master (
        output in_dout, in_empty, out_full,
        input  in_rd_en, out_din, out_wr_en
    );

    modport slave (
        input  in_dout, in_empty, out_full,
        output in_rd_en, out_din, out_wr_en
    );
endinterface

// File: rtl/gaussian_blur.sv
// 3x3 Gaussian smoothing (1 2 1 / 2 4 2 / 1 2 1, rounded >>4) over a raster
// stream, using a 2*WIDTH+2 pixel shift register as the line buffer.
module gaussian_blur #(
    parameter int WIDTH      = 720,
    parameter int HEIGHT     = 540,
    parameter int DATA_WIDTH = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    gaussian_blur_if.slave  bus
);
    localparam int NPIX   = WIDTH * HEIGHT;
    localparam int SR_LEN = 2 * WIDTH + 2;
    localparam int NW     = $clog2(NPIX + 1);
    localparam int RW     = $clog2(HEIGHT);
    localparam int CW     = $clog2(WIDTH);
    localparam int SW     = DATA_WIDTH + 4;

    typedef enum logic [1:0] {S_FILL, S_RUN, S_FLUSH} state_t;

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_sr [SR_LEN];
    logic [NW-1:0]         r_n;
    logic [RW-1:0]         r_row;
    logic [CW-1:0]         r_col;

    logic                  w_rd_en;
    logic                  w_wr_en;
    logic                  w_shift;
    logic [DATA_WIDTH-1:0] w_shift_in;
    logic [SW-1:0]         w_sum;
    logic [DATA_WIDTH-1:0] w_smooth;
    logic                  w_border;
    logic                  w_last_out;

    // Nothing pops or writes while reset is held, even if the FIFOs are ready.
    always_comb begin
        w_rd_en = 1'b0;
        w_wr_en = 1'b0;
        case (r_state)
            S_FILL:  w_rd_en = i_rst_n && !bus.in_empty;
            S_RUN: begin
                w_rd_en = i_rst_n && !bus.in_empty && !bus.out_full;
                w_wr_en = w_rd_en;
            end
            S_FLUSH: w_wr_en = i_rst_n && !bus.out_full;
            default: ;
        endcase
    end

    assign w_shift    = w_rd_en || (r_state == S_FLUSH && w_wr_en);
    assign w_shift_in = (r_state == S_FLUSH) ? '0 : bus.in_dout;

    // Bottom-right tap is the FIFO head, so pixel m completes on pop of m+W+1.
    assign w_sum = SW'(r_sr[2*WIDTH+1]) + (SW'(r_sr[2*WIDTH]) << 1) + SW'(r_sr[2*WIDTH-1])
                 + (SW'(r_sr[WIDTH+1]) << 1) + (SW'(r_sr[WIDTH]) << 2) + (SW'(r_sr[WIDTH-1]) << 1)
                 + SW'(r_sr[1]) + (SW'(r_sr[0]) << 1) + SW'(bus.in_dout);

    assign w_smooth   = DATA_WIDTH'((w_sum + SW'(8)) >> 4);
    assign w_border   = (r_row == '0) || (r_row == RW'(HEIGHT - 1))
                     || (r_col == '0) || (r_col == CW'(WIDTH - 1));
    assign w_last_out = (r_row == RW'(HEIGHT - 1)) && (r_col == CW'(WIDTH - 1));

    assign bus.in_rd_en  = w_rd_en;
    assign bus.out_wr_en = w_wr_en;
    assign bus.out_din   = w_border ? r_sr[WIDTH] : w_smooth;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_FILL;
            r_n     <= '0;
            r_row   <= '0;
            r_col   <= '0;
            for (int k = 0; k < SR_LEN; k++) r_sr[k] <= '0;
        end else begin
            if (w_shift) begin
                r_sr[0] <= w_shift_in;
                for (int k = 1; k < SR_LEN; k++) r_sr[k] <= r_sr[k-1];
            end
            if (w_rd_en) r_n <= r_n + 1'b1;
            if (w_wr_en) begin
                if (r_col == CW'(WIDTH - 1)) begin
                    r_col <= '0;
                    r_row <= r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            case (r_state)
                S_FILL:  if (w_rd_en && r_n == NW'(WIDTH)) r_state <= S_RUN;
                S_RUN:   if (w_rd_en && r_n == NW'(NPIX - 1)) r_state <= S_FLUSH;
                S_FLUSH: if (w_wr_en && w_last_out) begin
                    r_state <= S_FILL;
                    r_n     <= '0;
                    r_row   <= '0;
                    r_col   <= '0;
                end
                default: r_state <= S_FILL;
            endcase
        end
    end
endmodule
